// File: rtl/shift_exec_stage_pkg.sv
// Shared execute-stage definitions: shift opcodes, datapath widths and the
// bit-reversal helper used to build right shifts from a left shifter.
`timescale 1ns/1ps
package shift_exec_stage_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_OP_SLL = 2'b00,
        SHIFT_OP_SRL = 2'b01,
        SHIFT_OP_RSV = 2'b10,
        SHIFT_OP_SRA = 2'b11
    } shift_op_e;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle of the shift stage.
`timescale 1ns/1ps
interface shift_exec_stage_if
    import shift_exec_stage_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [XLEN-1:0]    in_a;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/shift_exec_stage_left_shift.sv
// The existing 32-bit combinational left shifter (LeftShift): a log-depth
// barrel, one conditional power-of-two shift per shamt bit.
`timescale 1ns/1ps
module shift_exec_stage_left_shift
    import shift_exec_stage_pkg::*;
(
    input  logic [XLEN-1:0]    a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [XLEN-1:0]    y_o
);
    logic [XLEN-1:0] stage_s;

    // Barrel stages, least significant shamt bit first
    always_comb begin
        stage_s = a_i;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt_i[i]) begin
                stage_s = stage_s << (32'd1 << i);
            end else begin
                stage_s = stage_s;
            end
        end
        y_o = stage_s;
    end
endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage RV32I shift execute stage (SLL/SRL/SRA). S1 holds the operands,
// S2 holds the result; right shifts reuse the left shifter via bit reversal.
`timescale 1ns/1ps
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    shift_exec_stage_if.slave      bus
);
    logic               s1_valid_q, s1_valid_d;
    shift_op_e          s1_op_q,    s1_op_d;
    logic [XLEN-1:0]    s1_a_q,     s1_a_d;
    logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
    logic               s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]    s2_result_q, s2_result_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

    logic               s2_adv_s;
    logic               in_ready_s;
    logic               in_hs_s;
    logic [XLEN-1:0]    ls_in_s;
    logic [XLEN-1:0]    ls_data_s;
    logic [XLEN-1:0]    ls_mask_s;
    logic [XLEN-1:0]    srl_s;
    logic [XLEN-1:0]    fill_s;
    logic [XLEN-1:0]    result_s;

    assign s2_adv_s   = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign in_ready_s = ~s1_valid_q | s2_adv_s;
    assign in_hs_s    = bus.in_valid & in_ready_s;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_tag    = s2_tag_q;

    shift_exec_stage_left_shift u_ls_data (
        .a_i     (ls_in_s),
        .shamt_i (s1_shamt_q),
        .y_o     (ls_data_s)
    );

    // An all-ones word shifted left, reversed and inverted gives the SRA sign fill
    shift_exec_stage_left_shift u_ls_mask (
        .a_i     ({XLEN{1'b1}}),
        .shamt_i (s1_shamt_q),
        .y_o     (ls_mask_s)
    );

    // Shift datapath between S1 and S2
    always_comb begin
        ls_in_s = (s1_op_q == SHIFT_OP_SLL) ? s1_a_q : bit_rev(s1_a_q);
        srl_s   = bit_rev(ls_data_s);
        if (s1_a_q[XLEN-1]) begin
            fill_s = ~bit_rev(ls_mask_s);
        end else begin
            fill_s = {XLEN{1'b0}};
        end
        case (s1_op_q)
            SHIFT_OP_SLL: result_s = ls_data_s;
            SHIFT_OP_SRL: result_s = srl_s;
            SHIFT_OP_SRA: result_s = srl_s | fill_s;
            SHIFT_OP_RSV: result_s = s1_a_q;
            default:      result_s = s1_a_q;
        endcase
    end

    // Next state of both stages; flush kills everything including a same-cycle accept
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_shamt_d  = s1_shamt_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_hs_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = shift_op_e'(bus.in_op);
            s1_a_d     = bus.in_a;
            s1_shamt_d = bus.in_shamt;
            s1_tag_d   = bus.in_tag;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = result_s;
            s2_tag_d    = s1_tag_q;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= SHIFT_OP_SLL;
            s1_a_q      <= {XLEN{1'b0}};
            s1_shamt_q  <= {SHAMT_W{1'b0}};
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_result_q <= {XLEN{1'b0}};
            s2_tag_q    <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: a reference shift model fills the
// expected queue on each accept; a negedge monitor pops it on each transfer.
`timescale 1ns/1ps
module tb_shift_exec_stage;
    import shift_exec_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    shift_exec_stage_if #(.TAG_W(5)) bus ();

    shift_exec_stage #(.TAG_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return $unsigned($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Scoreboard: pop on output transfer, push on accepted input
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_result", bus.out_result, mon_e.res);
                    chk("sb_tag", bus.out_tag, mon_e.tag);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back({bus.in_tag, ref_shift(bus.in_op, bus.in_a, bus.in_shamt)});
            end
        end
    end

    task automatic set_in(input logic v, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty pipe with out_ready high; checks the two-cycle latency
    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                           input logic [4:0] tag, input logic [31:0] exp);
        set_in(1'b1, op, a, sh, tag);
        @(negedge clk);
        chk("dir_accept", bus.in_ready, 1'b1);
        next_cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("dir_not_early", bus.out_valid, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("dir_valid", bus.out_valid, 1'b1);
        chk("dir_result", bus.out_result, exp);
        chk("dir_tag", bus.out_tag, tag);
        next_cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        logic        acc;
        int          sent;

        rst = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        bus.out_ready = 1'b0;
        repeat (2) next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_out_tag", bus.out_tag, 5'd0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        next_cyc();

        bus.out_ready = 1'b1;
        run_one(2'b00, 32'h00000001, 5'd31, 5'd9,  32'h80000000);
        run_one(2'b11, 32'h80000000, 5'd4,  5'd10, 32'hF8000000);
        run_one(2'b01, 32'h80000000, 5'd4,  5'd11, 32'h08000000);
        run_one(2'b11, 32'h7FFFFFFF, 5'd31, 5'd12, 32'h00000000);
        run_one(2'b00, 32'hDEADBEEF, 5'd0,  5'd13, 32'hDEADBEEF);
        run_one(2'b01, 32'hDEADBEEF, 5'd0,  5'd14, 32'hDEADBEEF);
        run_one(2'b11, 32'hDEADBEEF, 5'd0,  5'd15, 32'hDEADBEEF);
        run_one(2'b10, 32'hDEADBEEF, 5'd7,  5'd16, 32'hDEADBEEF);

        // Back-pressure: two ops fill the pipe, the third must stall
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b00, 32'h0000_0011, 5'd1, 5'd1);
        @(negedge clk);
        chk("bp_acc1", bus.in_ready, 1'b1);
        next_cyc();
        set_in(1'b1, 2'b01, 32'h8000_0022, 5'd2, 5'd2);
        @(negedge clk);
        chk("bp_acc2", bus.in_ready, 1'b1);
        next_cyc();
        set_in(1'b1, 2'b11, 32'h8000_0033, 5'd3, 5'd3);
        @(negedge clk);
        chk("bp_stall3", bus.in_ready, 1'b0);
        chk("bp_valid", bus.out_valid, 1'b1);
        held_res = bus.out_result;
        held_tag = bus.out_tag;
        chk("bp_head_tag", held_tag, 5'd1);
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            @(negedge clk);
            chk("bp_hold_res", bus.out_result, held_res);
            chk("bp_hold_tag", bus.out_tag, held_tag);
            chk("bp_hold_ready", bus.in_ready, 1'b0);
        end
        next_cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_acc3", bus.in_ready, 1'b1);
        chk("bp_out1", bus.out_tag, 5'd1);
        next_cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_v2", bus.out_valid, 1'b1);
        chk("bp_out2", bus.out_tag, 5'd2);
        next_cyc();
        @(negedge clk);
        chk("bp_v3", bus.out_valid, 1'b1);
        chk("bp_out3", bus.out_tag, 5'd3);
        next_cyc();
        @(negedge clk);
        chk("bp_empty", bus.out_valid, 1'b0);
        next_cyc();

        // Flush with both stages full and an op offered
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b00, 32'h0000_0F00, 5'd3, 5'd20);
        next_cyc();
        set_in(1'b1, 2'b01, 32'h0000_0F00, 5'd3, 5'd21);
        next_cyc();
        set_in(1'b1, 2'b11, 32'hF000_0000, 5'd3, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full_ready", bus.in_ready, 1'b0);
        chk("fl_full_valid", bus.out_valid, 1'b1);
        next_cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fl_no_out", bus.out_valid, 1'b0);
            next_cyc();
        end

        // Flush against a handshake on an empty pipe: the op is dropped
        set_in(1'b1, 2'b00, 32'h1234_5678, 5'd4, 5'd23);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ready_kept", bus.in_ready, 1'b1);
        next_cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_drop", bus.out_valid, 1'b0);
            next_cyc();
        end
        run_one(2'b01, 32'hF000_0000, 5'd8, 5'd24, 32'h00F0_0000);

        // Reset while both stages are full
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b00, 32'h0000_00AA, 5'd5, 5'd25);
        next_cyc();
        set_in(1'b1, 2'b00, 32'h0000_00BB, 5'd6, 5'd26);
        next_cyc();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_result", bus.out_result, 32'h0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        next_cyc();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_stale", bus.out_valid, 1'b0);
            next_cyc();
        end

        // Random traffic with random back-pressure
        acc = 1'b0;
        sent = 0;
        for (int c = 0; c < 3000 && sent < 60; c++) begin
            if (!bus.in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    set_in(1'b1, 2'($urandom_range(0, 3)), $urandom(),
                           ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            next_cyc();
        end
        chk("rand_sent", sent, 60);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sb_q.size() == 0) break;
            next_cyc();
        end
        chk("drain_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined RV32I shift execution stage covering SLL/SLLI, SRL/SRLI and SRA/SRAI.
- Sits in the execute path between operand select/issue (upstream) and the result/writeback mux (downstream).
- Wraps the existing 32-bit combinational left shifter. Right shifts are built by bit-reversal around that shifter.
- Two register stages with valid/ready handshakes on both sides; carries a destination tag alongside the data.

Parameters:
TAG_W, 5, width of pass-through destination tag (rd index)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all in-flight ops (branch mispredict/trap)
in_valid  input  1  upstream op present
in_ready  output  1  stage can accept op this cycle
in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
in_a  input  32  operand to shift (rs1)
in_shamt  input  5  shift amount (rs2[4:0] or imm[4:0], extracted upstream)
in_tag  input  TAG_W  destination tag
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_result  output  32  shift result
out_tag  output  TAG_W  tag of out_result

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - s1_valid = 0, s2_valid = 0, out_valid = 0, out_result = 0, out_tag = 0.
  - in_ready is 1 in the first cycle after reset.
- Stage 1 (S1) registers op, a, shamt and tag on an input handshake (in_valid & in_ready).
- Stage 2 (S2) registers the computed result and the tag. out_* are driven directly from S2 registers; no combinational path from in_* to out_*.
- Advance rules:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv.
  - in_ready depends on out_ready combinationally; this is acceptable.
- Latency and throughput:
  - Accepted at edge N, out_valid at edge N+2 if out_ready stays high.
  - Throughput 1 op/cycle.
  - Capacity 2 ops; order strictly preserved.
- Hold rule: out_result and out_tag are held stable while out_valid & ~out_ready.
- Arithmetic, with rev() = 32-bit bit reversal and LS() = left shifter:
  - SLL: LS(a, shamt).
  - SRL: rev(LS(rev(a), shamt)).
  - SRA: SRL | (a[31] ? ~rev(LS(32'hFFFFFFFF, shamt)) : 0).
  - Reserved op 10: result = a unshifted (no exception raised here).
  - shamt = 0: result = a for every op.
  - Computation happens between S1 and S2 (one combinational shift level per cycle).
- Shifter count: two LS instances are needed (data and sign-fill mask). Both are driven from S1 registers.
- Flush:
  - Next cycle s1_valid = 0 and s2_valid = 0.
  - flush has priority over a simultaneous input handshake; that op is dropped.
  - flush has priority over a pending output; out_valid drops the next cycle.
  - in_ready is unaffected by flush in the flush cycle.
  - Upstream must not count the op as accepted when flush = 1.
- Reset: rst has priority over flush and all handshakes. Reset mid-operation discards both stages with no output.
- Simultaneous output drain and input accept with both stages full:
  - S2 drains, S1 moves to S2, new op enters S1.
  - No bubble, no loss.

Decomposition:
- Shared execute package holds:
  - SHIFT_OP_SLL = 2'b00, SHIFT_OP_SRL = 2'b01, SHIFT_OP_SRA = 2'b11, SHIFT_OP_RSV = 2'b10.
  - XLEN = 32 and SHAMT_W = 5.
- Decode-side mapping lives upstream, not in this block:
  - funct3 001 → SLL.
  - funct3 101 → SRL or SRA, selected by funct7[5].
- Sub-module: the existing 32-bit left shifter (LeftShift), instantiated twice.
- Bit-reverse is a local function; no new sub-module.

Test Plan:
- SLL, a = 0x00000001, shamt = 31, out_ready = 1 → result 0x80000000 exactly 2 cycles after acceptance, tag preserved.
- Same input a = 0x80000000, shamt = 4 → SRA gives 0xF8000000, SRL gives 0x08000000. SRA with a = 0x7FFFFFFF, shamt = 31 → 0x00000000.
- shamt = 0 for ops 00/01/11, and op 10 with shamt = 7, all with a = 0xDEADBEEF → every result 0xDEADBEEF.
- Back-pressure:
  - Stimulus: out_ready = 0; push tags 1, 2, 3 back-to-back.
  - Required: tags 1 and 2 accepted, in_ready = 0 on the third, out_result/out_tag held stable.
  - Then raise out_ready: tags 1, 2, 3 emerge in order, one per cycle.
- Flush:
  - Stimulus: flush = 1 with both stages valid and in_valid = 1 in the same cycle.
  - Required: out_valid = 0 the next cycle; no result ever appears for the three ops.
  - Next op after the flush completes normally.
- Reset: rst = 1 for one cycle while both stages are full → out_valid = 0 and out_result = 0 next cycle, in_ready = 1; no stale result afterwards.
